sram_rw_arbiter: RTL and testbench

SRAM_RW_ARBITER -- requirements
Module: sram_rw_arbiter

---
 rtl/sram_rw_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sram_rw_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter
//
// Shares one single-port SRAM between two requesters. After reset the block zero-fills
// every SRAM word, one word per cycle, and only then starts granting requests. Requests
// are arbitrated round-robin, and at most one is granted per cycle. The winner drives the
// SRAM combinationally in its grant cycle. A read returns its data on the winner's
// response port one cycle later. At most one read response is outstanding. While that
// response waits for its ready, all new grants are held off.
//
// Parameters
//   ADDR_W  SRAM address width (DEPTH = 2**ADDR_W words)
//   DATA_W  SRAM data width
//   MASK_W  write-mask width; each mask bit covers DATA_W/MASK_W data bits
//
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for requester N (N = 0, 1)
//   reqN_write                   1 = write, 0 = read
//   reqN_addr / _mask / _wdata   request address, write mask and write data
//   respN_valid / respN_ready    read-response handshake for requester N
//   resp_rdata                   read data, shared by both response ports
//   init_done                    high once the zero-fill has completed
//   sram_en / sram_wmode         SRAM access enable and write mode
//   sram_addr / _wmask / _wdata  SRAM address, write mask and write data
//   sram_rdata                   SRAM read data; valid the cycle after a read, then held

module sram_rw_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned MASK_W = 16
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [MASK_W-1:0] req0_mask,
  input  logic [DATA_W-1:0] req0_wdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [MASK_W-1:0] req1_mask,
  input  logic [DATA_W-1:0] req1_wdata,

  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_rdata,

  output logic              init_done,

  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fill_cnt_q;
  logic              init_done_q;
  logic              prio_q;        // requester that wins the next tie
  logic              resp_pend_q;   // a read response is outstanding
  logic              resp_owner_q;  // requester that owns the outstanding response

  logic run;
  logic resp_accept;
  logic stall;
  logic can_grant;
  logic gnt0;
  logic gnt1;
  logic gnt;
  logic gnt_sel;
  logic gnt_write;

  // Grant path. Reset masks everything combinationally, so nothing is granted or
  // written in a reset cycle, even before the state has been cleared.
  assign run         = (state_q == StRun) && !reset;
  assign resp_accept = resp_pend_q && (resp_owner_q ? resp1_ready : resp0_ready);
  // An accepted response frees the slot in the same cycle, so reads can stream.
  assign stall       = resp_pend_q && !resp_accept;
  assign can_grant   = run && !stall;

  assign gnt0      = can_grant && req0_valid && (!req1_valid || !prio_q);
  assign gnt1      = can_grant && req1_valid && (!req0_valid ||  prio_q);
  assign gnt       = gnt0 || gnt1;
  assign gnt_sel   = gnt1;
  assign gnt_write = gnt_sel ? req1_write : req0_write;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // The SRAM holds read data until the next read. No read can be granted while a
  // response is pending, so the SRAM output is passed straight through.
  assign resp_rdata  = sram_rdata;
  assign resp0_valid = resp_pend_q && !resp_owner_q && !reset;
  assign resp1_valid = resp_pend_q &&  resp_owner_q && !reset;
  assign init_done   = init_done_q && !reset;

  // SRAM drive: the zero-fill owns the port during INIT; otherwise the winner owns it.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (!reset && (state_q == StInit)) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = fill_cnt_q;
      sram_wmask = '1;
      sram_wdata = '0;
    end else if (gnt) begin
      sram_en    = 1'b1;
      sram_wmode = gnt_write;
      sram_addr  = gnt_sel ? req1_addr  : req0_addr;
      sram_wmask = gnt_sel ? req1_mask  : req0_mask;
      sram_wdata = gnt_sel ? req1_wdata : req0_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StInit;
      fill_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      prio_q       <= 1'b0;
      resp_pend_q  <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          fill_cnt_q <= fill_cnt_q + 1'b1;
          if (fill_cnt_q == LastAddr) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: begin
          if (gnt) begin
            prio_q <= ~gnt_sel;
          end
          // A new read replaces a response that was accepted in the same cycle.
          if (gnt && !gnt_write) begin
            resp_pend_q  <= 1'b1;
            resp_owner_q <= gnt_sel;
          end else if (resp_accept) begin
            resp_pend_q <= 1'b0;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_one_grant : assert property (@(posedge clock) !(gnt0 && gnt1));
  a_one_resp  : assert property (@(posedge clock) !(resp0_valid && resp1_valid));
  a_no_init_gnt : assert property (@(posedge clock) (state_q == StInit) |-> !gnt);
`endif

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter. It contains a behavioural masked SRAM model, directed
// stimulus with hand-computed expectations, and a response scoreboard. The stimulus
// pushes the expected read data and port into the scoreboard. A separate monitor pops
// and compares each entry whenever a response handshake occurs.

module tb_sram_rw_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam logic [DATA_W-1:0] DAA = {16{8'hAA}};
  localparam logic [DATA_W-1:0] D10 = {16{8'h10}};
  localparam logic [DATA_W-1:0] D20 = {16{8'h20}};
  localparam logic [DATA_W-1:0] D07 = {16{8'h07}};

  logic              clock = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready, req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [MASK_W-1:0] req0_mask;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_ready, req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [MASK_W-1:0] req1_mask;
  logic [DATA_W-1:0] req1_wdata;
  logic              resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;

  sram_rw_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MASK_W (MASK_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_write  (req0_write),
    .req0_addr   (req0_addr),
    .req0_mask   (req0_mask),
    .req0_wdata  (req0_wdata),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_write  (req1_write),
    .req1_addr   (req1_addr),
    .req1_mask   (req1_mask),
    .req1_wdata  (req1_wdata),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_rdata  (resp_rdata),
    .init_done   (init_done),
    .sram_en     (sram_en),
    .sram_wmode  (sram_wmode),
    .sram_addr   (sram_addr),
    .sram_wmask  (sram_wmask),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  always #5 clock = ~clock;

  // SRAM model; starts with non-zero contents so that the zero-fill is observable.
  logic [DATA_W-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = {4{32'hDEADBEEF}} ^ DATA_W'(i);
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < int'(MASK_W); b++) begin
          if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic p, input logic [DATA_W-1:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: samples after the inputs have settled for the cycle.
  always @(negedge clock) begin
    exp_t e;
    #2;
    if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
      check("resp_excl", {resp1_valid, resp0_valid} & {2{resp1_valid & resp0_valid}}, '0);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: got response on port %0d expected none",
                 resp1_valid);
      end else begin
        e = sb.pop_front();
        check("resp_port", resp1_valid, e.port);
        check("resp_data", resp_rdata, e.data);
      end
    end
  end

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic req(input int n, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    if (n == 0) begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_mask = m; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_mask = m; req1_wdata = d;
    end
  endtask

  // Checks n consecutive fill cycles starting at address 0; call at a negedge.
  task automatic fill_check(input int n);
    logic [ADDR_W-1:0] ia;
    for (int i = 0; i < n; i++) begin
      ia = ADDR_W'(i);
      #1;
      check("fill", {sram_en, sram_wmode, sram_addr, sram_wmask, (sram_wdata == '0),
                     init_done, req0_ready, req1_ready},
                    {1'b1, 1'b1, ia, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0});
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_mask = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_mask = '0; req1_wdata = '0;
    resp0_ready = 0; resp1_ready = 0;

    // Reset state, then an idle zero-fill of exactly DEPTH cycles.
    @(negedge clock); #1;
    check("rst_en", sram_en, 0);
    check("rst_done", init_done, 0);
    check("rst_resp", {resp0_valid, resp1_valid}, 0);
    reset = 1'b0;
    fill_check(DEPTH);
    #1;
    check("init_done", init_done, 1);
    check("idle_en", sram_en, 0);

    // Write then read back on requester 0.
    @(negedge clock); req(0, 1'b1, 8'h05, 16'hFFFF, DAA); #1;
    check("wr_rdy", req0_ready, 1);
    check("wr_sram", {sram_en, sram_wmode, sram_addr, sram_wdata}, {1'b1, 1'b1, 8'h05, DAA});
    @(negedge clock); req(0, 1'b0, 8'h05, '0, '0); resp0_ready = 1'b1; push(1'b0, DAA); #1;
    check("rd_rdy", req0_ready, 1);
    check("rd_sram", {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, 8'h05});
    check("wr_noresp", resp0_valid, 0);
    @(negedge clock); idle(); #1;
    check("rd_resp_v", resp0_valid, 1);

    // Distinct data at 0x10/0x20; the last write by requester 1 gives requester 0 the tie.
    @(negedge clock); req(0, 1'b1, 8'h10, 16'hFFFF, D10); #1;
    check("wr10_rdy", req0_ready, 1);
    @(negedge clock); idle(); req(1, 1'b1, 8'h20, 16'hFFFF, D20); #1;
    check("wr20_rdy", req1_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      req(0, 1'b0, 8'h10, '0, '0); req(1, 1'b0, 8'h20, '0, '0);
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      push(k[0], k[0] ? D20 : D10);
      #1;
      check("alt_rdy", {req1_ready, req0_ready}, k[0] ? 2'b10 : 2'b01);
    end
    @(negedge clock); idle();

    // Response stall on requester 1 while requester 0 waits.
    @(negedge clock); req(1, 1'b1, 8'h07, 16'hFFFF, D07); #1;
    check("wr07_rdy", req1_ready, 1);
    @(negedge clock); req(1, 1'b0, 8'h07, '0, '0); resp1_ready = 1'b0; push(1'b1, D07); #1;
    check("rd07_rdy", req1_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); req1_valid = 1'b0; req(0, 1'b0, 8'h05, '0, '0); resp0_ready = 1'b1; #1;
      check("stall_r0", req0_ready, 0);
      check("stall_v1", resp1_valid, 1);
      check("stall_data", resp_rdata, D07);
      check("stall_en", sram_en, 0);
    end
    @(negedge clock); resp1_ready = 1'b1; push(1'b0, DAA); #1;
    check("unstall_r0", req0_ready, 1);
    @(negedge clock); idle(); #1;
    check("resp0_after", resp0_valid, 1);
    check("resp1_clear", resp1_valid, 0);

    // Byte-masked write over a zero-filled word.
    @(negedge clock); req(0, 1'b1, 8'h03, 16'h0001, '1); #1;
    check("mwr_rdy", req0_ready, 1);
    @(negedge clock); req(0, 1'b0, 8'h03, '0, '0); push(1'b0, 128'hFF); #1;
    check("mrd_rdy", req0_ready, 1);
    @(negedge clock); idle();

    // Reset drops a pending response; reset mid-fill restarts the fill.
    @(negedge clock); req(0, 1'b0, 8'h05, '0, '0); resp0_ready = 1'b0; #1;
    check("drop_rdy", req0_ready, 1);
    @(negedge clock); idle(); reset = 1'b1; #1;
    check("rst2_v0", resp0_valid, 0);
    check("rst2_en", sram_en, 0);
    check("rst2_done", init_done, 0);
    @(negedge clock); reset = 1'b0; resp0_ready = 1'b1; resp1_ready = 1'b1;
    req(0, 1'b0, 8'h05, '0, '0); req(1, 1'b0, 8'h03, '0, '0);
    fill_check(100);
    reset = 1'b1; #1;
    check("rst3_en", sram_en, 0);
    check("rst3_rdy", {req1_ready, req0_ready}, 0);
    check("rst3_v0", resp0_valid, 0);
    @(negedge clock); reset = 1'b0;
    fill_check(DEPTH);
    #1;
    check("refill_done", init_done, 1);
    check("tie_after_rst", {req1_ready, req0_ready}, 2'b01);
    push(1'b0, '0);
    @(negedge clock); #1;
    check("tie_next", {req1_ready, req0_ready}, 2'b10);
    push(1'b1, '0);
    @(negedge clock); idle();
    @(negedge clock);
    @(negedge clock);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
